vga_sync_gen: RTL and testbench

Raster timing generator for the room renderers. Divides `clk_vga` down to a pixel tick, runs horizontal/vertical counters for 640x480@60, and drives `CurrentX`/`CurrentY` into the room map modules (HallwayRight and its siblings). It also produces sync and blank signals delayed to line up with the room modules' registered `mapData`, plus a frame-start pulse and frame counter for sprite and animation logic.

---
 rtl/vga_sync_gen.sv | 131 +++++++++++++
 tb/tb_vga_sync_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-tick divider, h/v counters, delayed sync/blank,
// frame-start pulse and frame counter for the room renderers.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIX_DIV  = 4,
  parameter logic        SYNC_POL = 1'b0,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic       clk_vga,
  input  logic       rst,
  output logic [9:0] CurrentX,
  output logic [8:0] CurrentY,
  output logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       active,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC - 1;
  localparam logic [2:0]  PIPE_RST     = {~SYNC_POL, ~SYNC_POL, 1'b1};

  logic [3:0] r_div;
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_pix_tick;
  logic       r_frame_start;
  logic [7:0] r_frame_count;
  logic [2:0] r_d1;
  logic [2:0] r_d2;
  logic [2:0] r_d3;

  logic       w_div_wrap;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_active;
  logic       w_hsync_raw;
  logic       w_vsync_raw;
  logic [2:0] w_raw;
  logic [2:0] w_dly_out;

  assign w_div_wrap = (r_div == 4'(PIX_DIV - 1));
  assign w_h_last   = (r_h_cnt == 10'(H_TOTAL - 1));
  assign w_v_last   = (r_v_cnt == 10'(V_TOTAL - 1));

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      r_div         <= '0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_pix_tick    <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_pix_tick    <= w_div_wrap;
      r_frame_start <= 1'b0;
      if (w_div_wrap) begin
        r_div <= '0;
        if (w_h_last) begin
          r_h_cnt <= '0;
          if (w_v_last) begin
            r_v_cnt       <= '0;
            r_frame_start <= 1'b1;
            r_frame_count <= r_frame_count + 8'd1;
          end else begin
            r_v_cnt <= r_v_cnt + 10'd1;
          end
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end else begin
        r_div <= r_div + 4'd1;
      end
    end
  end

  assign w_active    = (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
  assign w_hsync_raw = ((r_h_cnt >= 10'(H_SYNC_START)) && (r_h_cnt <= 10'(H_SYNC_END)))
                       ? SYNC_POL : ~SYNC_POL;
  assign w_vsync_raw = ((r_v_cnt >= 10'(V_SYNC_START)) && (r_v_cnt <= 10'(V_SYNC_END)))
                       ? SYNC_POL : ~SYNC_POL;
  assign w_raw       = {w_hsync_raw, w_vsync_raw, ~w_active};

  // Fixed 3-deep chain; PIPE_DLY picks the tap, unused stages are pruned.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      r_d1 <= PIPE_RST;
      r_d2 <= PIPE_RST;
      r_d3 <= PIPE_RST;
    end else begin
      r_d1 <= w_raw;
      r_d2 <= r_d1;
      r_d3 <= r_d2;
    end
  end

  always_comb begin
    w_dly_out = w_raw;
    case (PIPE_DLY)
      0:       w_dly_out = w_raw;
      1:       w_dly_out = r_d1;
      2:       w_dly_out = r_d2;
      default: w_dly_out = r_d3;
    endcase
  end

  assign CurrentX    = r_h_cnt;
  assign CurrentY    = (r_v_cnt < 10'(V_ACTIVE)) ? r_v_cnt[8:0] : 9'(V_ACTIVE - 1);
  assign pix_tick    = r_pix_tick;
  assign hsync       = w_dly_out[2];
  assign vsync       = w_dly_out[1];
  assign blank       = w_dly_out[0];
  assign active      = w_active;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three builds checked every cycle against an
// arithmetic raster model driven by the count of clock edges since reset.
`timescale 1ns/1ps
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       tick;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       act;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic clk_vga = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_vga = ~clk_vga;

  int unsigned total = 0;
  int unsigned bad   = 0;
  longint      n_edges = 0;

  always @(posedge clk_vga or posedge rst) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  // A: small raster, PIX_DIV=2, PIPE_DLY=3, active-low sync
  logic [9:0] a_x; logic [8:0] a_y; logic [7:0] a_fc;
  logic a_tick, a_hs, a_vs, a_bl, a_act, a_fs;
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIX_DIV(2), .SYNC_POL(1'b0), .PIPE_DLY(3)
  ) u_a (
    .clk_vga(clk_vga), .rst(rst), .CurrentX(a_x), .CurrentY(a_y),
    .pix_tick(a_tick), .hsync(a_hs), .vsync(a_vs), .blank(a_bl),
    .active(a_act), .frame_start(a_fs), .frame_count(a_fc)
  );

  // B: small raster, PIX_DIV=1, PIPE_DLY=0, active-high sync
  logic [9:0] b_x; logic [8:0] b_y; logic [7:0] b_fc;
  logic b_tick, b_hs, b_vs, b_bl, b_act, b_fs;
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIX_DIV(1), .SYNC_POL(1'b1), .PIPE_DLY(0)
  ) u_b (
    .clk_vga(clk_vga), .rst(rst), .CurrentX(b_x), .CurrentY(b_y),
    .pix_tick(b_tick), .hsync(b_hs), .vsync(b_vs), .blank(b_bl),
    .active(b_act), .frame_start(b_fs), .frame_count(b_fc)
  );

  // C: default 640x480@60 build
  logic [9:0] c_x; logic [8:0] c_y; logic [7:0] c_fc;
  logic c_tick, c_hs, c_vs, c_bl, c_act, c_fs;
  vga_sync_gen u_c (
    .clk_vga(clk_vga), .rst(rst), .CurrentX(c_x), .CurrentY(c_y),
    .pix_tick(c_tick), .hsync(c_hs), .vsync(c_vs), .blank(c_bl),
    .active(c_act), .frame_start(c_fs), .frame_count(c_fc)
  );

  // Expected outputs after n edges: tick index t = n/pd gives position and
  // frame number directly; delayed signals look at the raster dly edges ago.
  function automatic obs_t model(longint n, longint ha, longint hf, longint hsw, longint hb,
                                 longint va, longint vf, longint vsw, longint vb,
                                 longint pd, longint dly, bit pol);
    longint ht, vt, ft, t, x, v, m, tm, xm, vm;
    obs_t o;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    ft = ht * vt;
    t  = n / pd;
    x  = t % ht;
    v  = (t / ht) % vt;
    o.x    = 10'(x);
    o.y    = (v < va) ? 9'(v) : 9'(va - 1);
    o.act  = (x < ha) && (v < va);
    o.tick = (n > 0) && (n % pd == 0);
    o.fs   = o.tick && (t % ft == 0);
    o.fc   = 8'((t / ft) % 256);
    m = n - dly;
    if (m < 0) begin
      o.hs = !pol;
      o.vs = !pol;
      o.bl = 1'b1;
    end else begin
      tm = m / pd;
      xm = tm % ht;
      vm = (tm / ht) % vt;
      o.hs = (xm >= ha + hf && xm < ha + hf + hsw) ? pol : !pol;
      o.vs = (vm >= va + vf && vm < va + vf + vsw) ? pol : !pol;
      o.bl = !((xm < ha) && (vm < va));
    end
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t got, input obs_t exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s n=%0d got x=%0d y=%0d tick=%b hs=%b vs=%b bl=%b act=%b fs=%b fc=%0d exp x=%0d y=%0d tick=%b hs=%b vs=%b bl=%b act=%b fs=%b fc=%0d",
             tag, n_edges, got.x, got.y, got.tick, got.hs, got.vs, got.bl, got.act, got.fs, got.fc,
             exp.x, exp.y, exp.tick, exp.hs, exp.vs, exp.bl, exp.act, exp.fs, exp.fc);
    end
  endtask

  task automatic check_all();
    chk("dutA", {a_x, a_y, a_tick, a_hs, a_vs, a_bl, a_act, a_fs, a_fc},
        model(n_edges, 8, 1, 2, 1, 5, 1, 2, 1, 2, 3, 1'b0));
    chk("dutB", {b_x, b_y, b_tick, b_hs, b_vs, b_bl, b_act, b_fs, b_fc},
        model(n_edges, 8, 1, 2, 1, 5, 1, 2, 1, 1, 0, 1'b1));
    chk("dutC", {c_x, c_y, c_tick, c_hs, c_vs, c_bl, c_act, c_fs, c_fc},
        model(n_edges, 640, 16, 96, 48, 480, 10, 2, 33, 4, 1, 1'b0));
  endtask

  task automatic run(input int unsigned cycles);
    repeat (cycles) begin
      @(negedge clk_vga);
      check_all();
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk_vga);
      check_all();
    end
    rst = 1'b0;
    // covers first tick, C's hsync/blank edges and its first line wrap
    run(3300);

    for (int k = 0; k < 6; k++) begin
      @(posedge clk_vga);
      #($urandom_range(1, 3));
      rst = 1'b1;
      #1;
      check_all();
      repeat (5) begin
        @(negedge clk_vga);
        check_all();
      end
      rst = 1'b0;
      run($urandom_range(20, 1500));
    end

    rst = 1'b1;
    @(negedge clk_vga);
    check_all();
    rst = 1'b0;
    // long enough for 256+ frames on A and B so frame_count wraps
    run(55400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
